// File: rtl/sram_ctrl.sv
// SRAM controller: runs one async-SRAM read or write per control-unit strobe.
// It also serves a memory-mapped I/O word at IO_ADDR (switch input, hex display output).
// Ports:
//   Clk, Reset (async, active-low)
//   Mem_OE/Mem_WE: active-low strobes. ADDR: word address. Data_to_mem: write data.
//   Switches: value returned by a read of IO_ADDR.
//   Data_from_mem: registered read data. Mem_Ready: one-cycle access-done pulse.
//   Hex_out: display register, written by a write to IO_ADDR.
//   SRAM_*: active-low SRAM controls, address, and data bus with its output enable.
module sram_ctrl #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_to_mem,
    input  logic [15:0] Switches,
    input  logic [15:0] SRAM_DQ_in,
    output logic [15:0] Data_from_mem,
    output logic        Mem_Ready,
    output logic [15:0] Hex_out,
    output logic [19:0] SRAM_ADDR,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE,
        RELEASE
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    addr_q, addr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic [15:0]    rdata_q, rdata_d;
    logic [15:0]    hex_q, hex_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hex_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        hex_d      = hex_q;
        cnt_d      = cnt_q;
        Mem_Ready  = 1'b0;
        SRAM_CE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        SRAM_WE_N  = 1'b1;
        SRAM_UB_N  = 1'b1;
        SRAM_LB_N  = 1'b1;
        SRAM_DQ_oe = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Write wins when both strobes are low.
                // I/O accesses leave the SRAM address/data registers untouched.
                if (!Mem_WE) begin
                    if (ADDR == IO_ADDR) begin
                        hex_d   = Data_to_mem;
                        state_d = DONE;
                    end else begin
                        addr_d  = ADDR;
                        wdata_d = Data_to_mem;
                        state_d = WR_SETUP;
                    end
                end else if (!Mem_OE) begin
                    if (ADDR == IO_ADDR) begin
                        rdata_d = Switches;
                        state_d = DONE;
                    end else begin
                        addr_d  = ADDR;
                        cnt_d   = CNT_INIT;
                        state_d = RD;
                    end
                end
            end
            RD: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                if (cnt_q == '0) begin
                    rdata_d = SRAM_DQ_in;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_SETUP: begin
                SRAM_CE_N  = 1'b0;
                SRAM_UB_N  = 1'b0;
                SRAM_LB_N  = 1'b0;
                SRAM_DQ_oe = 1'b1;
                cnt_d      = CNT_INIT;
                state_d    = WR_PULSE;
            end
            WR_PULSE: begin
                SRAM_CE_N  = 1'b0;
                SRAM_WE_N  = 1'b0;
                SRAM_UB_N  = 1'b0;
                SRAM_LB_N  = 1'b0;
                SRAM_DQ_oe = 1'b1;
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_HOLD: begin
                SRAM_CE_N  = 1'b0;
                SRAM_UB_N  = 1'b0;
                SRAM_LB_N  = 1'b0;
                SRAM_DQ_oe = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                Mem_Ready = 1'b1;
                state_d   = RELEASE;
            end
            RELEASE: begin
                // Wait for both strobes high so a held strobe is one access.
                if (Mem_OE && Mem_WE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Data_from_mem = rdata_q;
    assign Hex_out       = hex_q;
    assign SRAM_ADDR     = {4'b0, addr_q};
    assign SRAM_DQ_out   = wdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with WAIT_CYCLES=1 and IO_ADDR=16'hFFFF.
// It covers SRAM read/write timing, I/O access, held strobes, and reset abort.
module tb_sram_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Mem_OE, Mem_WE;
    logic [15:0] ADDR, Data_to_mem, Switches, SRAM_DQ_in;
    logic [15:0] Data_from_mem, Hex_out, SRAM_DQ_out;
    logic        Mem_Ready;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
    logic        SRAM_DQ_oe;

    int n_cmp = 0;
    int n_err = 0;
    int n_rdy, n_oe, n_we;

    sram_ctrl #(.WAIT_CYCLES(1), .IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset(Reset),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .ADDR(ADDR), .Data_to_mem(Data_to_mem),
        .Switches(Switches), .SRAM_DQ_in(SRAM_DQ_in),
        .Data_from_mem(Data_from_mem), .Mem_Ready(Mem_Ready),
        .Hex_out(Hex_out), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N),
        .SRAM_LB_N(SRAM_LB_N), .SRAM_DQ_out(SRAM_DQ_out),
        .SRAM_DQ_oe(SRAM_DQ_oe)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // OE_N and WE_N must never be low together.
    always @(negedge Clk) begin
        if (Reset === 1'b1) begin
            n_cmp++;
            assert ((SRAM_OE_N | SRAM_WE_N) === 1'b1) else begin
                n_err++;
                $error("FAIL oe_we_overlap: observed OE_N=%b WE_N=%b expected not both 0",
                       SRAM_OE_N, SRAM_WE_N);
            end
        end
    end

    initial begin
        Reset = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b1;
        ADDR = '0; Data_to_mem = '0; Switches = '0; SRAM_DQ_in = '0;
        #3;
        chk("rst_ready", Mem_Ready, 0);
        chk("rst_rdata", Data_from_mem, 0);
        chk("rst_hex", Hex_out, 0);
        chk("rst_addr", SRAM_ADDR, 0);
        chk("rst_ctrl", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 5'h1F);
        chk("rst_dqoe", SRAM_DQ_oe, 0);
        chk("rst_dqout", SRAM_DQ_out, 0);
        step(); step();
        Reset = 1'b1;
        step();

        // SRAM read at 0x0010
        SRAM_DQ_in = 16'hBEEF; ADDR = 16'h0010; Mem_OE = 1'b0;
        step();
        chk("rd1_oe", SRAM_OE_N, 0);
        chk("rd1_ce", SRAM_CE_N, 0);
        chk("rd1_bytes", {SRAM_UB_N, SRAM_LB_N}, 0);
        chk("rd1_addr", SRAM_ADDR, 20'h00010);
        chk("rd1_dqoe", SRAM_DQ_oe, 0);
        chk("rd1_rdy", Mem_Ready, 0);
        Mem_OE = 1'b1; ADDR = 16'h0055;
        step();
        chk("rd2_oe", SRAM_OE_N, 0);
        chk("rd2_addr", SRAM_ADDR, 20'h00010);
        chk("rd2_rdy", Mem_Ready, 0);
        step();
        chk("rd_done_rdy", Mem_Ready, 1);
        chk("rd_data", Data_from_mem, 16'hBEEF);
        chk("rd_done_oe", SRAM_OE_N, 1);
        step();
        chk("rd_rel_rdy", Mem_Ready, 0);
        step();

        // SRAM write 0x1234 to 0x0020
        ADDR = 16'h0020; Data_to_mem = 16'h1234; Mem_WE = 1'b0;
        step();
        chk("wr_setup_we", SRAM_WE_N, 1);
        chk("wr_setup_ce", SRAM_CE_N, 0);
        chk("wr_setup_dqoe", SRAM_DQ_oe, 1);
        chk("wr_setup_dq", SRAM_DQ_out, 16'h1234);
        chk("wr_addr", SRAM_ADDR, 20'h00020);
        Mem_WE = 1'b1; Data_to_mem = 16'hFFFF;
        step();
        chk("wr_pulse1_we", SRAM_WE_N, 0);
        chk("wr_pulse1_dq", SRAM_DQ_out, 16'h1234);
        step();
        chk("wr_pulse2_we", SRAM_WE_N, 0);
        chk("wr_pulse2_dqoe", SRAM_DQ_oe, 1);
        step();
        chk("wr_hold_we", SRAM_WE_N, 1);
        chk("wr_hold_ce", SRAM_CE_N, 0);
        chk("wr_hold_dqoe", SRAM_DQ_oe, 1);
        chk("wr_hold_rdy", Mem_Ready, 0);
        step();
        chk("wr_done_rdy", Mem_Ready, 1);
        chk("wr_done_dqoe", SRAM_DQ_oe, 0);
        chk("wr_done_ce", SRAM_CE_N, 1);
        chk("wr_keep_rdata", Data_from_mem, 16'hBEEF);
        step(); step();

        // I/O write then I/O read
        ADDR = 16'hFFFF; Data_to_mem = 16'h00A5; Mem_WE = 1'b0;
        step();
        chk("io_wr_rdy", Mem_Ready, 1);
        chk("io_wr_hex", Hex_out, 16'h00A5);
        chk("io_wr_ce", SRAM_CE_N, 1);
        chk("io_wr_addr", SRAM_ADDR, 20'h00020);
        Mem_WE = 1'b1;
        step(); step();
        Switches = 16'h0F0F; Mem_OE = 1'b0;
        step();
        chk("io_rd_rdy", Mem_Ready, 1);
        chk("io_rd_data", Data_from_mem, 16'h0F0F);
        chk("io_rd_ce", SRAM_CE_N, 1);
        Switches = 16'h0000; Mem_OE = 1'b1;
        step(); step();
        chk("io_rd_keep", Data_from_mem, 16'h0F0F);

        // Read strobe held for 10 cycles
        ADDR = 16'h0040; SRAM_DQ_in = 16'h7777; Mem_OE = 1'b0;
        n_rdy = 0; n_oe = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (Mem_Ready === 1'b1) n_rdy++;
            if (SRAM_OE_N === 1'b0) n_oe++;
        end
        chk("hold_rdy_cnt", n_rdy, 1);
        chk("hold_oe_cnt", n_oe, 2);
        chk("hold_data", Data_from_mem, 16'h7777);
        Mem_OE = 1'b1;
        step(); step();
        chk("hold_idle_oe", SRAM_OE_N, 1);
        Mem_OE = 1'b0; SRAM_DQ_in = 16'h5A5A;
        step();
        chk("hold_again_oe", SRAM_OE_N, 0);
        Mem_OE = 1'b1;
        step(); step();
        chk("hold_again_rdy", Mem_Ready, 1);
        chk("hold_again_data", Data_from_mem, 16'h5A5A);
        step(); step();

        // Both strobes low: write wins
        ADDR = 16'h0030; Data_to_mem = 16'hCAFE;
        Mem_OE = 1'b0; Mem_WE = 1'b0;
        n_rdy = 0; n_oe = 0; n_we = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 0) begin
                chk("both_addr", SRAM_ADDR, 20'h00030);
                chk("both_dq", SRAM_DQ_out, 16'hCAFE);
                Mem_OE = 1'b1; Mem_WE = 1'b1;
            end
            if (Mem_Ready === 1'b1) n_rdy++;
            if (SRAM_OE_N === 1'b0) n_oe++;
            if (SRAM_WE_N === 1'b0) n_we++;
        end
        chk("both_rdy_cnt", n_rdy, 1);
        chk("both_oe_cnt", n_oe, 0);
        chk("both_we_cnt", n_we, 2);
        chk("both_keep_rdata", Data_from_mem, 16'h5A5A);

        // Reset during WR_PULSE
        ADDR = 16'h0050; Data_to_mem = 16'h9999; Mem_WE = 1'b0;
        step();
        Mem_WE = 1'b1;
        step();
        chk("rst_mid_pulse", SRAM_WE_N, 0);
        #2 Reset = 1'b0;
        #1;
        chk("rst_mid_we", SRAM_WE_N, 1);
        chk("rst_mid_dqoe", SRAM_DQ_oe, 0);
        chk("rst_mid_rdy", Mem_Ready, 0);
        chk("rst_mid_hex", Hex_out, 0);
        chk("rst_mid_addr", SRAM_ADDR, 0);
        chk("rst_mid_rdata", Data_from_mem, 0);
        n_rdy = 0;
        Mem_OE = 1'b0; ADDR = 16'h0060; SRAM_DQ_in = 16'h1357;
        for (int i = 0; i < 3; i++) begin
            step();
            if (Mem_Ready === 1'b1) n_rdy++;
        end
        chk("rst_hold_rdy", n_rdy, 0);
        chk("rst_hold_ce", SRAM_CE_N, 1);

        // Strobe held through reset release is accepted on first clock
        Reset = 1'b1;
        step();
        chk("post_rst_oe", SRAM_OE_N, 0);
        chk("post_rst_addr", SRAM_ADDR, 20'h00060);
        Mem_OE = 1'b1;
        step(); step();
        chk("post_rst_rdy", Mem_Ready, 1);
        chk("post_rst_data", Data_from_mem, 16'h1357);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
